// File: rtl/usb_utm_tx_ser.sv
// usb_utm_tx_ser: UTM transmit serialiser.
// Takes parallel words from the UTMI tx side and drives the USB line.
// In normal mode (op_mode 0 or 3) a packet is SYNC, then bit-stuffed and
// NRZI-encoded data, then an EOP. Raw mode (op_mode 2) sends the data bits
// directly as J/K levels, with no SYNC, stuffing or EOP. Non-driving mode
// (op_mode 1) never starts a packet.
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   suspend_m     0 = suspend: abort any packet and release the line
//   op_mode[1:0]  0 normal, 1 non-driving, 2 raw, 3 same as 0
//   data_in       word to transmit, sent LSB first
//   tx_valid      data_in is valid
//   tx_ready      data_in is captured in this cycle
//   tx_dp, tx_dn  line levels (J = 1/0, K = 0/1, SE0 = 0/0), registered
//   tx_oe         line driver enable
//   tx_active     high from packet start to the end of EOP
//
// Handshake: the source raises tx_valid and holds data_in stable until
// tx_ready. tx_ready is a combinational one-cycle pulse. A word is transferred
// in a cycle where tx_valid and tx_ready are both high. tx_ready is never high
// in two consecutive cycles, and it pulses at most once per word.
module usb_utm_tx_ser #(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 4,
  parameter int STUFF_LEN   = 6,
  parameter int EOP_SE0_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              suspend_m,
  input  logic [1:0]        op_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_dp,
  output logic              tx_dn,
  output logic              tx_oe,
  output logic              tx_active
);
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = (EOP_SE0_LEN > 1) ? $clog2(EOP_SE0_LEN) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [EW-1:0] SE0_LAST  = EW'(EOP_SE0_LEN - 1);
  localparam logic [OW-1:0] STUFF_AT  = OW'(STUFF_LEN);
  localparam logic [BW-1:0] WORD_BITS = BW'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]        sync_cnt_q, sync_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     left_q, left_d;     // data bits still waiting in shreg
  logic [OW-1:0]     ones_q, ones_d;     // consecutive 1s sent (stuffing)
  logic [EW-1:0]     eop_cnt_q, eop_cnt_d;
  logic              raw_q, raw_d;       // packet mode, latched at start
  logic              level_q, level_d;   // NRZI line level, 1 = J
  logic              dp_d, dn_d, oe_d, active_d;

  logic              tick;
  logic              data_step;
  logic              emit_en, emit_bit;
  logic [DATA_W-1:0] eff_sh;
  logic [BW-1:0]     eff_left;

  assign tick      = (state_q != S_IDLE) && (bit_cnt_q == BIT_LAST);
  // Bit boundaries where the next data-path bit is chosen: the end of the
  // last SYNC bit, and every bit boundary in DATA.
  assign data_step = tick && ((state_q == S_DATA) ||
                              (state_q == S_SYNC && sync_cnt_q == 3'd7));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    shreg_d   = shreg_q;
    left_d    = left_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    raw_d     = raw_q;
    level_d   = level_q;
    dp_d      = tx_dp;
    dn_d      = tx_dn;
    oe_d      = tx_oe;
    active_d  = tx_active;
    tx_ready  = 1'b0;
    emit_en   = 1'b0;
    emit_bit  = 1'b0;
    eff_sh    = shreg_q;
    eff_left  = left_q;

    if (state_q != S_IDLE) begin
      bit_cnt_d = tick ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid && op_mode != 2'd1) begin
          oe_d      = 1'b1;
          active_d  = 1'b1;
          bit_cnt_d = '0;
          ones_d    = '0;
          emit_en   = 1'b1;
          if (op_mode == 2'd2) begin
            // Raw mode has no SYNC, so the first word goes out immediately.
            raw_d    = 1'b1;
            state_d  = S_DATA;
            tx_ready = 1'b1;
            shreg_d  = data_in >> 1;
            left_d   = BW'(DATA_W - 1);
            emit_bit = data_in[0];
          end else begin
            raw_d      = 1'b0;
            state_d    = S_SYNC;
            sync_cnt_d = '0;
            left_d     = '0;
            emit_bit   = 1'b0;
          end
        end
      end
      S_SYNC: begin
        if (tick && sync_cnt_q != 3'd7) begin
          sync_cnt_d = sync_cnt_q + 1'b1;
          emit_en    = 1'b1;
          emit_bit   = (sync_cnt_q == 3'd6);
          // The final SYNC 1 counts toward the first stuffing run.
          if (sync_cnt_q == 3'd6) ones_d = OW'(1);
        end
      end
      S_EOP_SE0: begin
        if (tick) begin
          if (eop_cnt_q == SE0_LAST) begin
            state_d = S_EOP_J;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
          end else begin
            eop_cnt_d = eop_cnt_q + 1'b1;
          end
        end
      end
      S_EOP_J: begin
        if (tick) begin
          state_d  = S_IDLE;
          oe_d     = 1'b0;
          active_d = 1'b0;
          level_d  = 1'b1;
          dp_d     = 1'b1;
          dn_d     = 1'b0;
        end
      end
      default: ;
    endcase

    if (data_step) begin
      state_d = S_DATA;
      // An empty shifter refills at the boundary even if a stuff bit is due.
      // The new word then waits behind the stuff bit.
      if (left_q == '0 && tx_valid) begin
        tx_ready = 1'b1;
        eff_sh   = data_in;
        eff_left = WORD_BITS;
      end
      if (!raw_q && ones_q == STUFF_AT) begin
        emit_en  = 1'b1;
        emit_bit = 1'b0;
        ones_d   = '0;
        shreg_d  = eff_sh;
        left_d   = eff_left;
      end else if (eff_left != '0) begin
        emit_en  = 1'b1;
        emit_bit = eff_sh[0];
        ones_d   = eff_sh[0] ? ones_q + 1'b1 : '0;
        shreg_d  = eff_sh >> 1;
        left_d   = eff_left - 1'b1;
      end else if (raw_q) begin
        state_d  = S_IDLE;
        oe_d     = 1'b0;
        active_d = 1'b0;
        level_d  = 1'b1;
        dp_d     = 1'b1;
        dn_d     = 1'b0;
      end else begin
        state_d   = S_EOP_SE0;
        eop_cnt_d = '0;
        dp_d      = 1'b0;
        dn_d      = 1'b0;
      end
    end

    if (emit_en) begin
      level_d = raw_d ? emit_bit : (emit_bit ? level_q : !level_q);
      dp_d    = level_d;
      dn_d    = !level_d;
    end

    if (!suspend_m) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      left_d    = '0;
      ones_d    = '0;
      oe_d      = 1'b0;
      active_d  = 1'b0;
      level_d   = 1'b1;
      dp_d      = 1'b1;
      dn_d      = 1'b0;
      tx_ready  = 1'b0;
    end
    if (!rst) tx_ready = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      shreg_q    <= '0;
      left_q     <= '0;
      ones_q     <= '0;
      eop_cnt_q  <= '0;
      raw_q      <= 1'b0;
      level_q    <= 1'b1;
      tx_dp      <= 1'b1;
      tx_dn      <= 1'b0;
      tx_oe      <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      shreg_q    <= shreg_d;
      left_q     <= left_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
      raw_q      <= raw_d;
      level_q    <= level_d;
      tx_dp      <= dp_d;
      tx_dn      <= dn_d;
      tx_oe      <= oe_d;
      tx_active  <= active_d;
    end
  end
endmodule
